score_rx: RTL and testbench



---
 rtl/score_rx.sv | 194 +++++++++++++++++++
 tb/tb_score_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_rx.sv
// Receiver for the multiplexed two-digit score bus: synchronizes the pins, filters each digit,
// decodes 7-segment patterns and tracks blanking / game-over from the display blink pattern.

module score_filter #(
  parameter int STABLE_COUNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample,
  input  logic [3:0] value,
  output logic [3:0] score
);

  localparam int CW = $clog2(STABLE_COUNT + 1);

  logic [3:0]    cand;
  logic [3:0]    cand_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // A differing sample restarts the candidate; the score only follows a full run of matches.
  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    if (sample) begin
      if (value == cand) begin
        if (cnt != CW'(STABLE_COUNT))
          cnt_nxt = cnt + 1'b1;
      end else begin
        cand_nxt = value;
        cnt_nxt  = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand  <= '0;
      cnt   <= '0;
      score <= '0;
    end else begin
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
      if (sample && (cnt_nxt == CW'(STABLE_COUNT)))
        score <= cand_nxt;
    end
  end

endmodule

module score_rx #(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_COUNT    = 2,
  parameter int BLANK_TIMEOUT   = 16,
  parameter int GAMEOVER_BLINKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] score_i,
  input  logic       cath1_i,
  input  logic       cath2_i,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [6:0] seg_p1,
  output logic [6:0] seg_p2,
  output logic       blanked,
  output logic       game_over,
  output logic       bus_err
);

  localparam int BW = $clog2(BLANK_TIMEOUT + 1);
  localparam int KW = $clog2(GAMEOVER_BLINKS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BLANK, ST_OVER} state_t;

  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [3:0]    s_score;
  logic          s_c1;
  logic          s_c2;
  logic          p1_smp;
  logic          p2_smp;
  logic          idle_smp;
  logic          conf_smp;
  logic          active;
  logic [BW-1:0] blank_cnt;
  logic [BW-1:0] blank_nxt;
  logic          blank_rise;
  logic [KW-1:0] blink_cnt;
  state_t        state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sync_q <= '0;
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], {score_i, cath1_i, cath2_i}};
  end

  assign {s_score, s_c1, s_c2} = sync_q[SYNC_STAGES-1];
  assign p1_smp   = s_c1 & ~s_c2;
  assign p2_smp   = ~s_c1 & s_c2;
  assign idle_smp = ~s_c1 & ~s_c2;
  assign conf_smp = s_c1 & s_c2;
  assign active   = p1_smp | p2_smp;

  score_filter #(.STABLE_COUNT(STABLE_COUNT)) u_filt_p1 (
    .clk(clk), .reset(reset), .sample(p1_smp), .value(s_score), .score(score_p1)
  );

  score_filter #(.STABLE_COUNT(STABLE_COUNT)) u_filt_p2 (
    .clk(clk), .reset(reset), .sample(p2_smp), .value(s_score), .score(score_p2)
  );

  // Conflict cycles neither advance nor clear the blank run.
  always_comb begin
    blank_nxt = blank_cnt;
    if (active)
      blank_nxt = '0;
    else if (idle_smp && (blank_cnt != BW'(BLANK_TIMEOUT)))
      blank_nxt = blank_cnt + 1'b1;
  end

  assign blank_rise = idle_smp && (blank_cnt == BW'(BLANK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_cnt <= '0;
      blanked   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      blank_cnt <= blank_nxt;
      blanked   <= (blank_nxt == BW'(BLANK_TIMEOUT));
      bus_err   <= bus_err | conf_smp;
    end
  end

  // Blink periods only count once the display has been seen running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      blink_cnt <= '0;
      game_over <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (active)
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (blank_rise) begin
            state <= ST_BLANK;
            if (blink_cnt != KW'(GAMEOVER_BLINKS))
              blink_cnt <= blink_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (active) begin
            if (blink_cnt >= KW'(GAMEOVER_BLINKS)) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        default: begin
          state     <= ST_OVER;
          game_over <= 1'b1;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign seg_p1 = seg7(score_p1);
  assign seg_p2 = seg7(score_p2);

endmodule

// File: tb/tb_score_rx.sv
// Directed bench for score_rx: stimulus pushes expected output snapshots keyed by cycle,
// a negedge monitor pops and compares them.

module tb_score_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] score_i;
  logic       cath1_i;
  logic       cath2_i;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [6:0] seg_p1;
  logic [6:0] seg_p2;
  logic       blanked;
  logic       game_over;
  logic       bus_err;

  typedef struct {
    int         at_cyc;
    string      name;
    logic [3:0] p1;
    logic [3:0] p2;
    logic       bl;
    logic       go;
    logic       be;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_drive = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   flush = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  score_rx dut (
    .clk(clk), .reset(reset), .score_i(score_i), .cath1_i(cath1_i), .cath2_i(cath2_i),
    .score_p1(score_p1), .score_p2(score_p2), .seg_p1(seg_p1), .seg_p2(seg_p2),
    .blanked(blanked), .game_over(game_over), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input exp_t e);
    logic [6:0] s1;
    logic [6:0] s2;
    s1 = seg_tab[e.p1];
    s2 = seg_tab[e.p2];
    n_cmp++;
    if (score_p1 !== e.p1 || score_p2 !== e.p2 || seg_p1 !== s1 || seg_p2 !== s2 ||
        blanked !== e.bl || game_over !== e.go || bus_err !== e.be) begin
      n_fail++;
      $display("[TB] FAIL %s @%0d: got p1=%0d p2=%0d s1=%h s2=%h bl=%b go=%b be=%b, want p1=%0d p2=%0d s1=%h s2=%h bl=%b go=%b be=%b",
               e.name, cyc, score_p1, score_p2, seg_p1, seg_p2, blanked, game_over, bus_err,
               e.p1, e.p2, s1, s2, e.bl, e.go, e.be);
    end
  endtask

  // Pending expectations whose cycle has passed, or that remain at the end, count as failures.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at_cyc == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end else if (sb[i].at_cyc < cyc || flush) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: expected at cycle %0d, never checked (now %0d)",
                 sb[i].name, sb[i].at_cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic expectAt(input string name, input int at, input logic [3:0] p1,
                          input logic [3:0] p2, input logic bl, input logic go, input logic be);
    exp_t e;
    e.at_cyc = at;
    e.name   = name;
    e.p1     = p1;
    e.p2     = p2;
    e.bl     = bl;
    e.go     = go;
    e.be     = be;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic c1, input logic c2, input logic [3:0] v);
    @(posedge clk);
    #1;
    cath1_i    = c1;
    cath2_i    = c2;
    score_i    = v;
    last_drive = cyc;
  endtask

  task automatic drivePairs(input logic [3:0] a, input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b0, a);
      applyStimulus(1'b0, 1'b1, b);
    end
  endtask

  task automatic driveIdle(input int n);
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, 1'b0, 4'd0);
  endtask

  task automatic pulseReset(input string name);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    cath1_i = 1'b0;
    cath2_i = 1'b0;
    score_i = 4'd0;
    expectAt(name, cyc, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int d0;
    int dd;
    int dc;
    reset   = 1'b1;
    score_i = 4'd0;
    cath1_i = 1'b0;
    cath2_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expectAt("reset_state", cyc, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Alternating 3/7: P1 valid 5 edges after first pin change, P2 one edge later.
    applyStimulus(1'b1, 1'b0, 4'd3);
    d0 = last_drive;
    expectAt("p1_not_yet", d0 + 4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    expectAt("p1_first_valid", d0 + 5, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    expectAt("p2_first_valid", d0 + 6, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd7);
    drivePairs(4'd3, 4'd7, 5);

    // Single-sample glitch, then two consecutive P1=5 slots.
    applyStimulus(1'b1, 1'b0, 4'd5);
    expectAt("glitch_hold", last_drive + 3, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd7);
    applyStimulus(1'b1, 1'b0, 4'd3);
    expectAt("glitch_recover", last_drive + 3, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd7);
    applyStimulus(1'b1, 1'b0, 4'd5);
    expectAt("p1_5_first", last_drive + 3, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd7);
    applyStimulus(1'b1, 1'b0, 4'd5);
    expectAt("p1_5_second", last_drive + 3, 4'd5, 4'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd7);

    driveIdle(15);
    expectAt("blank15_no", last_drive + 3, 4'd5, 4'd7, 1'b0, 1'b0, 1'b0);
    drivePairs(4'd5, 4'd7, 3);

    applyStimulus(1'b0, 1'b0, 4'd0);
    dd = last_drive;
    expectAt("blank_pre", dd + 17, 4'd5, 4'd7, 1'b0, 1'b0, 1'b0);
    expectAt("blank_rise", dd + 18, 4'd5, 4'd7, 1'b1, 1'b0, 1'b0);
    expectAt("blank_held", dd + 22, 4'd5, 4'd7, 1'b1, 1'b0, 1'b0);
    expectAt("blank_clear", dd + 23, 4'd5, 4'd7, 1'b0, 1'b0, 1'b0);
    driveIdle(19);
    drivePairs(4'd5, 4'd7, 2);

    // Fresh start, then two blink periods at 9/4.
    pulseReset("reset_again");
    drivePairs(4'd9, 4'd4, 10);
    driveIdle(20);
    drivePairs(4'd9, 4'd4, 10);
    expectAt("no_gameover_1st", last_drive + 3, 4'd9, 4'd4, 1'b0, 1'b0, 1'b0);
    driveIdle(20);
    applyStimulus(1'b1, 1'b0, 4'd9);
    expectAt("gameover_pre", last_drive + 2, 4'd9, 4'd4, 1'b1, 1'b0, 1'b0);
    expectAt("gameover_rise", last_drive + 3, 4'd9, 4'd4, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd4);
    drivePairs(4'd9, 4'd4, 9);
    expectAt("gameover_sticky", last_drive + 3, 4'd9, 4'd4, 1'b0, 1'b1, 1'b0);

    // A conflict between idles neither advances nor clears the blank run.
    driveIdle(15);
    applyStimulus(1'b1, 1'b1, 4'd2);
    dc = last_drive;
    expectAt("conflict_pre", dc + 2, 4'd9, 4'd4, 1'b0, 1'b1, 1'b0);
    expectAt("conflict_flag", dc + 3, 4'd9, 4'd4, 1'b0, 1'b1, 1'b1);
    expectAt("conflict_blank", dc + 4, 4'd9, 4'd4, 1'b1, 1'b1, 1'b1);
    expectAt("conflict_clear", dc + 5, 4'd9, 4'd4, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd4);
    applyStimulus(1'b1, 1'b0, 4'd9);
    applyStimulus(1'b0, 1'b1, 4'd12);
    expectAt("p2_12_first", last_drive + 3, 4'd9, 4'd4, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd9);
    applyStimulus(1'b0, 1'b1, 4'd12);
    expectAt("p2_12_second", last_drive + 3, 4'd9, 4'd12, 1'b0, 1'b1, 1'b1);

    // Reset with one P1=6 sample absorbed by the filter.
    applyStimulus(1'b1, 1'b0, 4'd6);
    expectAt("mid_filter", last_drive + 3, 4'd9, 4'd12, 1'b0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1, 4'd12);
    pulseReset("reset_mid");
    applyStimulus(1'b1, 1'b0, 4'd6);
    expectAt("post_reset_1", last_drive + 3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    expectAt("post_reset_2", last_drive + 5, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd0);
    applyStimulus(1'b1, 1'b0, 4'd6);
    applyStimulus(1'b0, 1'b1, 4'd0);

    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
